sync_fifo_fwft_w144_d256: RTL and testbench



---
 rtl/sync_fifo_fwft_w144_d256.sv | 79 +++++++
 tb/tb_sync_fifo_fwft_w144_d256.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft_w144_d256.sv
// 256 x 144 single-clock first-word-fall-through FIFO with occupancy count.
// The head word lives in a registered output stage; data_count includes it.
module sync_fifo_fwft_w144_d256 (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] din,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic [143:0] dout,
  output logic         full,
  output logic         empty,
  output logic [8:0]   data_count
);

  logic [143:0] mem [0:255];
  logic [7:0]   wr_ptr;
  logic [7:0]   rd_ptr;
  logic         out_valid;
  logic         wr_acc;
  logic         rd_acc;
  logic         mem_has;
  logic         load;

  // The array never holds 256 words (one is always in the output stage
  // once the array is non-empty), so pointer equality means "array empty".
  always_comb begin
    wr_acc  = wr_en & ~full;
    rd_acc  = rd_en & out_valid;
    mem_has = (wr_ptr != rd_ptr);
    load    = mem_has & (~out_valid | rd_acc);
  end

  assign empty = ~out_valid;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 8'd0;
      rd_ptr     <= 8'd0;
      out_valid  <= 1'b0;
      dout       <= '0;
      data_count <= 9'd0;
      full       <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 8'd1;
      end

      if (load) begin
        dout      <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 8'd1;
        out_valid <= 1'b1;
      end else if (rd_acc) begin
        out_valid <= 1'b0;
      end

      case ({wr_acc, rd_acc})
        2'b10: begin
          data_count <= data_count + 9'd1;
          full       <= (data_count == 9'd255);
        end
        2'b01: begin
          data_count <= data_count - 9'd1;
          full       <= 1'b0;
        end
        default: begin
          data_count <= data_count;
          full       <= full;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_fwft_w144_d256.sv
// Randomized scoreboard bench for the 256 x 144 FWFT FIFO.
// Reference model: a queue of accepted words plus the edge each was written on.
module tb_sync_fifo_fwft_w144_d256;

  logic         clk = 1'b0;
  logic         rst;
  logic [143:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [143:0] dout;
  logic         full;
  logic         empty;
  logic [8:0]   data_count;

  int checks   = 0;
  int failures = 0;

  logic [143:0] exp_q [$];
  int unsigned  wedge_q [$];
  int unsigned  cur_edge = 0;
  bit           rst_edge = 1'b0;

  sync_fifo_fwft_w144_d256 dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  function automatic logic [143:0] rand_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[143:0];
  endfunction

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. A word is on dout after edge j iff it is the oldest
  // stored word and was written on an edge strictly before j.
  always @(posedge clk) begin
    bit vis;
    bit rd_ok;
    bit wr_ok;
    if (rst) begin
      wedge_q.delete();
      exp_q.delete();
      rst_edge = 1'b1;
    end else begin
      vis   = (wedge_q.size() > 0) && (wedge_q[0] < cur_edge);
      rd_ok = rd_en && vis;
      wr_ok = wr_en && (wedge_q.size() < 256);
      if (rd_ok) void'(wedge_q.pop_front());
      if (wr_ok) begin
        wedge_q.push_back(cur_edge + 1);
        exp_q.push_back(din);
      end
      rst_edge = 1'b0;
    end
    cur_edge++;
  end

  // Monitor: status against the model, and dout against the scoreboard head.
  always @(negedge clk) begin
    bit m_vis;
    m_vis = (wedge_q.size() > 0) && (wedge_q[0] < cur_edge);
    check("data_count", 144'(data_count), 144'(wedge_q.size()));
    check("full", 144'(full), 144'(wedge_q.size() == 256));
    check("empty", 144'(empty), 144'(!m_vis));
    if (rst_edge) check("dout_reset", dout, 144'(0));
    if (!empty) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dout_unexpected: got %h expected no word presented", dout);
      end else begin
        check("dout_order", dout, exp_q[0]);
        if (rd_en && !rst) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [143:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int guard;
    logic w;
    logic r;
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    drive(1'b1, 1'b0, rand_word());
    drive(1'b1, 1'b1, rand_word());
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);

    // single word fall-through then pop
    drive(1'b1, 1'b0, 144'hA5);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, '0);

    // fill with 0..255, overflow attempt, drain past empty
    for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, 144'(i));
    drive(1'b1, 1'b0, 144'(999));
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 258; i++) drive(1'b0, 1'b1, '0);

    // steady state at 100, then full with simultaneous read+write
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, rand_word());
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, rand_word());
    guard = 0;
    while (wedge_q.size() < 256 && guard < 400) begin
      drive(1'b1, 1'b0, rand_word());
      guard++;
    end
    drive(1'b1, 1'b0, rand_word());
    drive(1'b1, 1'b1, rand_word());
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 260; i++) drive(1'b0, 1'b1, '0);

    // random stream of 600 accepted writes
    n = 0;
    guard = 0;
    while (n < 600 && guard < 5000) begin
      w = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 5);
      if (w && wedge_q.size() < 256) n++;
      drive(w, r, rand_word());
      guard++;
    end
    check("stream_writes", 144'(n), 144'(600));
    for (int i = 0; i < 300; i++) drive(1'b0, ($urandom_range(0, 3) != 0), '0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, '0);

    // reset with 241 words stored, then a fresh word must come out
    for (int i = 0; i < 241; i++) drive(1'b1, 1'b0, rand_word());
    rst = 1'b1;
    drive(1'b1, 1'b1, rand_word());
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 144'h5A5A_0000_0000_0000_0000_0000_0000_0000_C3C3);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);

    check("scoreboard_drained", 144'(exp_q.size()), 144'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
